ff256ct_seq_engine: RTL and testbench

Sequential, parametrised GF(256) cosine-transform coprocessor on a Wishbone classic slave port. It computes X_k = XOR over j of (beta[k][j] · x[j]) for an N-byte vector, using a single GF(256) multiply-accumulate unit over N·N cycles. Forward and inverse coefficient matrices are selectable per run. Results are committed atomically, and busy/done/error are exposed on a status register and a side-band port. It replaces the fully combinational 8-row direct transform where area matters more than latency.

---
 rtl/ff256ct_seq_engine.sv | 186 ++++++++++++++++++
 tb/tb_ff256ct_seq_engine.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ff256ct_seq_engine.sv
// GF(256) cosine-transform coprocessor behind a Wishbone classic slave.
// One multiply-accumulate per cycle; the N*N-cycle result is committed to XOUT at once.
module ff256ct_seq_engine #(
    parameter int               N          = 8,
    parameter int               DATA_WIDTH = 32,
    parameter int               BE_WIDTH   = 4,
    parameter int               ADR_WIDTH  = 3,
    parameter logic [8:0]       POLY       = 9'h11B,
    parameter logic [8*N*N-1:0] BETAS_FWD  = '0,
    parameter logic [8*N*N-1:0] BETAS_INV  = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADR_WIDTH-1:0]  adr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  we_i,
    input  logic [BE_WIDTH-1:0]   sel_i,
    input  logic                  stb_i,
    input  logic                  cyc_i,
    output logic                  ack_o,
    output logic [1:0]            status_o
);
    localparam int                   NW       = N / 4;
    localparam int                   IDX_W    = $clog2(N);
    localparam logic [ADR_WIDTH-1:0] ADR_CTRL = ADR_WIDTH'(N / 2);
    localparam logic [ADR_WIDTH-1:0] ADR_STAT = ADR_WIDTH'(N / 2 + 1);
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(N - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_MAC = 2'd2} state_t;

    // Shift-and-add multiply with on-the-fly reduction by the low byte of POLY.
    function automatic logic [7:0] gfmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            else      p = p;
            if (aa[7]) aa = (aa << 1) ^ POLY[7:0];
            else       aa = aa << 1;
        end
        return p;
    endfunction

    state_t              state_r, state_s;
    logic [8*N-1:0]      xin_r, xw_r, shadow_r, xout_r, shadow_s;
    logic [7:0]          acc_r, coef_s, xbyte_s, mac_s;
    logic [IDX_W-1:0]    k_r, j_r;
    logic                mode_r, mode_run_r, done_r, err_r, busy_r;
    logic                bus_acc_s, wr_s, start_s, start_ok_s, last_j_s, last_s;
    logic [DATA_WIDTH-1:0] rdata_s;
    int                  byte_idx_s;

    assign bus_acc_s  = cyc_i & stb_i & ~ack_o;
    assign wr_s       = bus_acc_s & we_i;
    assign start_s    = wr_s & (adr_i == ADR_CTRL) & data_i[0];
    assign start_ok_s = start_s & (state_r == S_IDLE);
    assign last_j_s   = (j_r == IDX_LAST);
    assign last_s     = (state_r == S_MAC) & last_j_s & (k_r == IDX_LAST);
    assign status_o   = {done_r, busy_r};

    // MAC datapath: coefficient fetch, multiply, and shadow row merge.
    always_comb begin
        byte_idx_s = int'(k_r) * N + int'(j_r);
        if (mode_run_r) coef_s = BETAS_INV[8*byte_idx_s +: 8];
        else            coef_s = BETAS_FWD[8*byte_idx_s +: 8];
        xbyte_s  = xw_r[8*int'(j_r) +: 8];
        mac_s    = acc_r ^ gfmul(coef_s, xbyte_s);
        shadow_s = shadow_r;
        shadow_s[8*int'(k_r) +: 8] = mac_s;
    end

    // Register-map read multiplexer.
    always_comb begin
        rdata_s = '0;
        for (int w = 0; w < NW; w++) begin
            if (adr_i == ADR_WIDTH'(w))           rdata_s = xin_r[32*w +: 32];
            else if (adr_i == ADR_WIDTH'(NW + w)) rdata_s = xout_r[32*w +: 32];
            else                                  rdata_s = rdata_s;
        end
        if (adr_i == ADR_CTRL)      rdata_s = {{(DATA_WIDTH-2){1'b0}}, mode_r, 1'b0};
        else if (adr_i == ADR_STAT) rdata_s = {{(DATA_WIDTH-3){1'b0}}, err_r, done_r, busy_r};
        else                        rdata_s = rdata_s;
    end

    // Next-state logic for IDLE -> LOAD -> MAC -> IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start_ok_s) state_s = S_LOAD;
                else            state_s = S_IDLE;
            end
            S_LOAD: state_s = S_MAC;
            S_MAC: begin
                if (last_s) state_s = S_IDLE;
                else        state_s = S_MAC;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_r <= S_IDLE;
        else        state_r <= state_s;
    end

    // Bus handshake, read data capture, XIN byte-lane writes and MODE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_o  <= 1'b0;
            data_o <= '0;
            xin_r  <= '0;
            mode_r <= 1'b0;
        end else begin
            ack_o <= bus_acc_s;
            if (bus_acc_s) data_o <= rdata_s;
            for (int w = 0; w < NW; w++) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_s && (adr_i == ADR_WIDTH'(w)) && sel_i[b])
                        xin_r[32*w + 8*b +: 8] <= data_i[8*b +: 8];
                end
            end
            if (wr_s && (adr_i == ADR_CTRL)) mode_r <= data_i[1];
        end
    end

    // Status flags; MODE is latched for the run when START is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            busy_r     <= 1'b0;
            mode_run_r <= 1'b0;
        end else begin
            busy_r <= (state_s != S_IDLE);
            if (start_ok_s) begin
                done_r     <= 1'b0;
                mode_run_r <= data_i[1];
            end else if (last_s) begin
                done_r <= 1'b1;
            end else if (wr_s && (adr_i == ADR_STAT) && data_i[1]) begin
                done_r <= 1'b0;
            end
            if (start_s && (state_r != S_IDLE))                    err_r <= 1'b1;
            else if (wr_s && (adr_i == ADR_STAT) && data_i[2])     err_r <= 1'b0;
        end
    end

    // Snapshot, row/column counters, accumulator and atomic XOUT commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xw_r     <= '0;
            shadow_r <= '0;
            xout_r   <= '0;
            acc_r    <= 8'h00;
            k_r      <= '0;
            j_r      <= '0;
        end else begin
            case (state_r)
                S_LOAD: begin
                    xw_r  <= xin_r;
                    acc_r <= 8'h00;
                    k_r   <= '0;
                    j_r   <= '0;
                end
                S_MAC: begin
                    if (last_j_s) begin
                        shadow_r <= shadow_s;
                        acc_r    <= 8'h00;
                        j_r      <= '0;
                        k_r      <= k_r + IDX_W'(1);
                        if (last_s) xout_r <= shadow_s;
                    end else begin
                        acc_r <= mac_s;
                        j_r   <= j_r + IDX_W'(1);
                    end
                end
                default: acc_r <= acc_r;
            endcase
        end
    end
endmodule

// File: tb/tb_ff256ct_seq_engine.sv
// Self-checking bench: an N=8 engine (identity / GF-multiply matrices) and an N=4
// engine with a dense forward matrix and its inverse, driven over Wishbone.
module tb_ff256ct_seq_engine;
    localparam logic [511:0] FWD_A = 512'h0100000000000000_0001000000000000_0000010000000000_0000000100000000_0000000001000000_0000000000010000_0000000000000100_0000000000000001;
    localparam logic [511:0] INV_A = (512'h57 << 64) | 512'h53;
    localparam logic [127:0] FWD_B = 128'h01000000_00530000_C0500300_40200002;
    localparam logic [127:0] INV_B = 128'h01000000_00CA0000_403CF600_2014008D;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  adr = 3'd0;
    logic [31:0] wdata = 32'h0;
    logic        we = 1'b0, cyc = 1'b0, stb_a = 1'b0, stb_b = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] rdata_a, rdata_b;
    logic        ack_a, ack_b;
    logic [1:0]  status_a, status_b;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct { string name; logic [31:0] exp; } sb_t;
    typedef struct { string name; bit b; bit w; logic [2:0] adr; logic [31:0] wd; logic [3:0] sel; logic [31:0] exp; } vec_t;
    sb_t  sb_q[$];
    vec_t tbl[$];

    ff256ct_seq_engine #(.N(8), .ADR_WIDTH(3), .BETAS_FWD(FWD_A), .BETAS_INV(INV_A)) dut_a (
        .clk(clk), .reset(reset), .adr_i(adr), .data_i(wdata), .data_o(rdata_a), .we_i(we),
        .sel_i(sel), .stb_i(stb_a), .cyc_i(cyc), .ack_o(ack_a), .status_o(status_a));

    ff256ct_seq_engine #(.N(4), .ADR_WIDTH(3), .BETAS_FWD(FWD_B), .BETAS_INV(INV_B)) dut_b (
        .clk(clk), .reset(reset), .adr_i(adr), .data_i(wdata), .data_o(rdata_b), .we_i(we),
        .sel_i(sel), .stb_i(stb_b), .cyc_i(cyc), .ack_o(ack_b), .status_o(status_b));

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [31:0] ref_xform4(input logic [127:0] m, input logic [31:0] x);
        logic [31:0] y;
        y = 32'h0;
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++)
                y[8*k +: 8] = y[8*k +: 8] ^ ref_mul(m[8*(4*k+j) +: 8], x[8*j +: 8]);
        return y;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic access(input bit b, input bit w, input logic [2:0] a, input logic [31:0] d,
                          input logic [3:0] s, input string name, input logic [31:0] exp);
        sb_t e;
        bit  got;
        if (!w) sb_q.push_back('{name, exp});
        @(negedge clk);
        adr = a; wdata = d; we = w; sel = s; cyc = 1'b1; stb_a = ~b; stb_b = b;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            got = b ? ack_b : ack_a;
        end
        cyc = 1'b0; stb_a = 1'b0; stb_b = 1'b0; we = 1'b0;
        check({name, " ack"}, {31'h0, got}, 32'h1);
        if (!w) begin
            e = sb_q.pop_front();
            if (got) check(e.name, b ? rdata_b : rdata_a, e.exp);
        end
    endtask

    task automatic wait_done(input bit b, input int lat, input string name);
        int         n;
        logic [1:0] st, prev;
        n = 0;
        st = b ? status_b : status_a;
        prev = st;
        do begin
            prev = st;
            @(posedge clk); #1;
            n++;
            st = b ? status_b : status_a;
        end while (!st[1] && n < 300);
        if (lat >= 0) begin
            check({name, " latency"}, 32'(n), 32'(lat));
            check({name, " status before done"}, {30'h0, prev}, 32'h1);
        end
        check({name, " status at done"}, {30'h0, st}, 32'h2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2:0]  acks;
        logic [31:0] yb;
        tbl.push_back('{"rst xin0",      1'b0, 1'b0, 3'd0, 32'h0,        4'h0, 32'h00000000});
        tbl.push_back('{"rst xout0",     1'b0, 1'b0, 3'd2, 32'h0,        4'h0, 32'h00000000});
        tbl.push_back('{"rst ctrl",      1'b0, 1'b0, 3'd4, 32'h0,        4'h0, 32'h00000000});
        tbl.push_back('{"rst status",    1'b0, 1'b0, 3'd5, 32'h0,        4'h0, 32'h00000000});
        tbl.push_back('{"unmapped rd",   1'b0, 1'b0, 3'd6, 32'h0,        4'h0, 32'h00000000});
        tbl.push_back('{"wr xin0 sel",   1'b0, 1'b1, 3'd0, 32'hFFFFFFFF, 4'h5, 32'h0});
        tbl.push_back('{"xin0 bytesel",  1'b0, 1'b0, 3'd0, 32'h0,        4'h0, 32'h00FF00FF});
        tbl.push_back('{"wr xin0",       1'b0, 1'b1, 3'd0, 32'h03020100, 4'hF, 32'h0});
        tbl.push_back('{"wr xin1",       1'b0, 1'b1, 3'd1, 32'h07060504, 4'hF, 32'h0});
        tbl.push_back('{"xin0",          1'b0, 1'b0, 3'd0, 32'h0,        4'h0, 32'h03020100});
        tbl.push_back('{"xin1",          1'b0, 1'b0, 3'd1, 32'h0,        4'h0, 32'h07060504});
        tbl.push_back('{"wr mode",       1'b0, 1'b1, 3'd4, 32'h00000002, 4'h0, 32'h0});
        tbl.push_back('{"ctrl mode",     1'b0, 1'b0, 3'd4, 32'h0,        4'h0, 32'h00000002});
        tbl.push_back('{"wr mode0",      1'b0, 1'b1, 3'd4, 32'h00000000, 4'hF, 32'h0});
        tbl.push_back('{"wr unmapped",   1'b0, 1'b1, 3'd7, 32'hFFFFFFFF, 4'hF, 32'h0});
        tbl.push_back('{"unmapped rd7",  1'b0, 1'b0, 3'd7, 32'h0,        4'h0, 32'h00000000});
        tbl.push_back('{"wr xout ro",    1'b0, 1'b1, 3'd2, 32'hDEADBEEF, 4'hF, 32'h0});
        tbl.push_back('{"xout ro",       1'b0, 1'b0, 3'd2, 32'h0,        4'h0, 32'h00000000});
        tbl.push_back('{"b rst status",  1'b1, 1'b0, 3'd3, 32'h0,        4'h0, 32'h00000000});

        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst status_o", {30'h0, status_a}, 32'h0);
        check("rst data_o", rdata_a, 32'h0);
        check("rst ack_o", {31'h0, ack_a}, 32'h0);

        foreach (tbl[i]) access(tbl[i].b, tbl[i].w, tbl[i].adr, tbl[i].wd, tbl[i].sel, tbl[i].name, tbl[i].exp);

        // held strobe: ack must drop for a cycle between accepted transfers
        repeat (2) @(negedge clk);
        adr = 3'd0; we = 1'b0; cyc = 1'b1; stb_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            acks[i] = ack_a;
        end
        cyc = 1'b0; stb_a = 1'b0;
        check("ack single cycle", {29'h0, acks}, 32'h5);

        // identity run, 65-cycle latency
        access(1'b0, 1'b1, 3'd4, 32'h1, 4'hF, "start id", 32'h0);
        wait_done(1'b0, 65, "identity");
        access(1'b0, 1'b0, 3'd2, 32'h0, 4'h0, "id xout0", 32'h03020100);
        access(1'b0, 1'b0, 3'd3, 32'h0, 4'h0, "id xout1", 32'h07060504);
        access(1'b0, 1'b0, 3'd4, 32'h0, 4'h0, "ctrl after run", 32'h0);
        access(1'b0, 1'b0, 3'd5, 32'h0, 4'h0, "status done", 32'h2);

        // GF multiply via inverse matrix (MODE=1)
        access(1'b0, 1'b1, 3'd0, 32'h000000CA, 4'hF, "wr x ca", 32'h0);
        access(1'b0, 1'b1, 3'd1, 32'h0, 4'hF, "wr x1 0", 32'h0);
        access(1'b0, 1'b1, 3'd4, 32'h3, 4'hF, "start gf1", 32'h0);
        access(1'b0, 1'b0, 3'd2, 32'h0, 4'h0, "xout held in run", 32'h03020100);
        access(1'b0, 1'b0, 3'd5, 32'h0, 4'h0, "status busy", 32'h1);
        wait_done(1'b0, -1, "gf1");
        access(1'b0, 1'b0, 3'd2, 32'h0, 4'h0, "gf1 xout0", {16'h0, ref_mul(8'h57, 8'hCA), 8'h01});
        access(1'b0, 1'b0, 3'd3, 32'h0, 4'h0, "gf1 xout1", 32'h0);
        access(1'b0, 1'b1, 3'd0, 32'h00000083, 4'h1, "wr x 83", 32'h0);
        access(1'b0, 1'b1, 3'd4, 32'h3, 4'hF, "start gf2", 32'h0);
        wait_done(1'b0, 65, "gf2");
        access(1'b0, 1'b0, 3'd2, 32'h0, 4'h0, "gf2 xout0", {16'h0, 8'hC1, ref_mul(8'h53, 8'h83)});
        access(1'b0, 1'b0, 3'd3, 32'h0, 4'h0, "gf2 xout1", 32'h0);

        // START during a run sets ERR; XIN and MODE writes do not disturb it
        access(1'b0, 1'b1, 3'd4, 32'h1, 4'hF, "start err run", 32'h0);
        repeat (9) @(posedge clk);
        access(1'b0, 1'b1, 3'd4, 32'h1, 4'hF, "start in run", 32'h0);
        access(1'b0, 1'b1, 3'd0, 32'h11223344, 4'hF, "wr xin in run", 32'h0);
        access(1'b0, 1'b1, 3'd4, 32'h2, 4'hF, "wr mode in run", 32'h0);
        access(1'b0, 1'b0, 3'd5, 32'h0, 4'h0, "status err busy", 32'h5);
        wait_done(1'b0, -1, "err run");
        access(1'b0, 1'b0, 3'd2, 32'h0, 4'h0, "err run xout0", 32'h00000083);
        access(1'b0, 1'b0, 3'd4, 32'h0, 4'h0, "ctrl mode kept", 32'h2);
        access(1'b0, 1'b0, 3'd5, 32'h0, 4'h0, "status err done", 32'h6);
        access(1'b0, 1'b1, 3'd5, 32'h4, 4'h0, "clr err", 32'h0);
        access(1'b0, 1'b0, 3'd5, 32'h0, 4'h0, "status err clr", 32'h2);
        access(1'b0, 1'b1, 3'd5, 32'h2, 4'h0, "clr done", 32'h0);
        access(1'b0, 1'b0, 3'd5, 32'h0, 4'h0, "status done clr", 32'h0);

        // reset mid-run aborts without DONE and clears XOUT
        access(1'b0, 1'b1, 3'd4, 32'h1, 4'hF, "start rst run", 32'h0);
        repeat (20) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("mid-run rst status_o", {30'h0, status_a}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        access(1'b0, 1'b0, 3'd2, 32'h0, 4'h0, "rst xout0 cleared", 32'h0);
        access(1'b0, 1'b0, 3'd5, 32'h0, 4'h0, "rst no done", 32'h0);
        access(1'b0, 1'b1, 3'd0, 32'h0A0B0C0D, 4'hF, "wr x post rst", 32'h0);
        access(1'b0, 1'b1, 3'd4, 32'h1, 4'hF, "start post rst", 32'h0);
        wait_done(1'b0, 65, "post rst");
        access(1'b0, 1'b0, 3'd2, 32'h0, 4'h0, "post rst xout0", 32'h0A0B0C0D);

        // N=4 dense forward transform then inverse round trip
        yb = ref_xform4(FWD_B, 32'h4A3B2C1D);
        access(1'b1, 1'b1, 3'd0, 32'h4A3B2C1D, 4'hF, "b wr x", 32'h0);
        access(1'b1, 1'b1, 3'd2, 32'h1, 4'hF, "b start fwd", 32'h0);
        wait_done(1'b1, 17, "b fwd");
        access(1'b1, 1'b0, 3'd1, 32'h0, 4'h0, "b fwd xout", yb);
        access(1'b1, 1'b1, 3'd0, yb, 4'hF, "b wr y", 32'h0);
        access(1'b1, 1'b1, 3'd2, 32'h3, 4'hF, "b start inv", 32'h0);
        wait_done(1'b1, 17, "b inv");
        access(1'b1, 1'b0, 3'd1, 32'h0, 4'h0, "b roundtrip", 32'h4A3B2C1D);
        access(1'b1, 1'b0, 3'd2, 32'h0, 4'h0, "b ctrl mode", 32'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
